// File: rtl/bcd_display_scanner_pkg.sv
// Shared types and constants for the BCD counter / display scanner.
// A digit code of DIGIT_BLANK is rendered dark by the downstream 7-segment decoder.
package bcd_display_scanner_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_BLANK = 4'hF;
    localparam bcd_digit_t BCD_MAX     = 4'd9;
    localparam bcd_digit_t BCD_ZERO    = 4'd0;

endpackage

// File: rtl/bcd_display_scanner_digit_counter.sv
// One decade cell of the BCD counter: counts 0..9 on inc, carries out when rolling 9 -> 0.
// clr overrides inc; the carry is purely combinational so a ripple settles within one cycle.
module bcd_digit_counter
    import bcd_display_scanner_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    bcd_digit_t q_q;
    bcd_digit_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = BCD_ZERO;
        end else if (inc) begin
            q_d = (q_q == BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_display_scanner.sv
// Multi-digit BCD up-counter with a time-multiplexed, registered digit/anode scan output.
// Holds the tick prescaler, refresh counter, scan index and leading-zero blanking mux.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 50000000,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    blank_lz,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    wrap,
    output logic [3:0]              digit,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int PRE_W  = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SCAN_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [REF_W-1:0]      REF_LAST  = REF_W'(REFRESH_DIV - 1);
    localparam logic [SCAN_W-1:0]     SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_RESET  = ~NUM_DIGITS'(1);

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [REF_W-1:0]      ref_q, ref_d;
    logic [SCAN_W-1:0]     scan_q, scan_d;
    logic                  wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    bcd_digit_t            digit_q, digit_d;

    logic       tick;
    logic       tick_eff;
    logic       zero_run;
    bcd_digit_t cnt_digit  [NUM_DIGITS];
    bcd_digit_t disp_digit [NUM_DIGITS];

    // clr wins over a coincident tick, so the tick never reaches the digit chain.
    always_comb begin
        tick     = en && (pre_q == PRE_LAST);
        tick_eff = tick && !clr;
        pre_d    = pre_q;
        if (clr || tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic       cell_inc;
            logic       cell_carry;
            bcd_digit_t cell_q;

            if (gi == 0) begin : g_first
                assign cell_inc = tick_eff;
            end else begin : g_next
                assign cell_inc = g_digit[gi-1].cell_carry;
            end

            bcd_digit_counter u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (cell_inc),
                .q     (cell_q),
                .carry (cell_carry)
            );

            assign cnt_digit[gi]           = cell_q;
            assign count_bcd[4*gi +: 4]    = cell_q;
        end
    endgenerate

    // A carry out of the top digit is exactly the all-9s rollover.
    assign wrap_d = g_digit[NUM_DIGITS-1].cell_carry;

    always_comb begin
        ref_d  = (ref_q == REF_LAST) ? '0 : ref_q + REF_W'(1);
        scan_d = scan_q;
        if (ref_q == REF_LAST) begin
            scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SCAN_W'(1);
        end
    end

    // Walk from the most significant digit down; zero_run stays high while all digits so far are 0.
    always_comb begin
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run && (cnt_digit[k] == BCD_ZERO);
            disp_digit[k] = (k != 0 && blank_lz && zero_run) ? DIGIT_BLANK : cnt_digit[k];
        end
    end

    always_comb begin
        digit_d = BCD_ZERO;
        an_d    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_q == SCAN_W'(k)) begin
                digit_d = disp_digit[k];
                an_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q   <= '0;
            ref_q   <= '0;
            scan_q  <= '0;
            wrap_q  <= 1'b0;
            an_q    <= AN_RESET;
            digit_q <= BCD_ZERO;
        end else begin
            pre_q   <= pre_d;
            ref_q   <= ref_d;
            scan_q  <= scan_d;
            wrap_q  <= wrap_d;
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    assign wrap  = wrap_q;
    assign an    = an_q;
    assign digit = digit_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: a decimal reference model pushes expected count/wrap per clock,
// popped and compared after each edge; scenario tasks add scan and blanking checks.
module tb_bcd_display_scanner;

    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, clr, blank_lz;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  digit;
    logic [3:0]  an;

    logic        rst2_n, en2, clr2, blank2;
    logic [7:0]  count2;
    logic        wrap2;
    logic [3:0]  digit2;
    logic [1:0]  an2;

    int total = 0;
    int bad   = 0;
    int m_pre = 0;
    int m_val = 0;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wr;
    } exp_t;

    exp_t sb[$];

    bcd_display_scanner #(.NUM_DIGITS(4), .TICK_DIV(4), .REFRESH_DIV(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .blank_lz  (blank_lz),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .digit     (digit),
        .an        (an)
    );

    bcd_display_scanner #(.NUM_DIGITS(2), .TICK_DIV(4), .REFRESH_DIV(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .en        (en2),
        .clr       (clr2),
        .blank_lz  (blank2),
        .count_bcd (count2),
        .wrap      (wrap2),
        .digit     (digit2),
        .an        (an2)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Advance the model with the currently driven inputs, then clock the DUT and compare.
    task automatic step();
        exp_t e;
        exp_t got;
        e.wr = 1'b0;
        if (!rst_n || clr) begin
            m_pre = 0;
            m_val = 0;
        end else if (en) begin
            if (m_pre == TD - 1) begin
                m_pre = 0;
                if (m_val == 9999) begin
                    m_val = 0;
                    e.wr  = 1'b1;
                end else begin
                    m_val++;
                end
            end else begin
                m_pre++;
            end
        end
        e.cnt = to_bcd(m_val);
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        total++;
        if (count_bcd !== got.cnt || wrap !== got.wr) begin
            bad++;
            $display("FAIL scoreboard: count_bcd=%h wrap=%b required count_bcd=%h wrap=%b",
                     count_bcd, wrap, got.cnt, got.wr);
        end
    endtask

    task automatic count_to(input int target);
        int n;
        n = 0;
        en = 1'b1;
        while (m_val != target && n < 3000) begin
            step();
            n++;
        end
        en = 1'b0;
        total++;
        if (count_bcd !== to_bcd(target)) begin
            bad++;
            $display("FAIL count_to: count_bcd=%h required %h", count_bcd, to_bcd(target));
        end
    endtask

    task automatic clear_count();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; clr = 1'b0; blank_lz = 1'b0;
        repeat (3) begin
            step();
            total++;
            if (an !== 4'b1110 || digit !== 4'h0) begin
                bad++;
                $display("FAIL reset_hold: an=%b digit=%h required an=1110 digit=0", an, digit);
            end
        end
        rst_n = 1'b1;
        step();
        total++;
        if (an !== 4'b1110 || digit !== 4'h0) begin
            bad++;
            $display("FAIL reset_release: an=%b digit=%h required an=1110 digit=0", an, digit);
        end
    endtask

    task automatic test_count_carry();
        logic [15:0] prev;
        int seen;
        rst_n = 1'b0; en = 1'b0;
        step();
        rst_n = 1'b1; en = 1'b1;
        prev = count_bcd;
        seen = 0;
        repeat (44) begin
            step();
            if (prev[3:0] == 4'd9 && count_bcd[3:0] != 4'd9) begin
                seen++;
                total++;
                if (count_bcd[7:0] !== 8'h10) begin
                    bad++;
                    $display("FAIL carry_edge: count_bcd=%h required low byte 10", count_bcd);
                end
            end
            prev = count_bcd;
        end
        en = 1'b0;
        total++;
        if (count_bcd !== 16'h0011) begin
            bad++;
            $display("FAIL count_44: count_bcd=%h required 0011", count_bcd);
        end
        total++;
        if (seen != 1) begin
            bad++;
            $display("FAIL carry_seen: edges=%0d required 1", seen);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] prev2;
        int wraps;
        en = 1'b0;
        rst2_n = 1'b0; en2 = 1'b0;
        @(posedge clk); #1;
        rst2_n = 1'b1; en2 = 1'b1;
        prev2 = count2;
        wraps = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (wrap2 === 1'b1) begin
                wraps++;
                total++;
                if (count2 !== 8'h00 || prev2 !== 8'h99) begin
                    bad++;
                    $display("FAIL wrap_align: count=%h prev=%h required count=00 prev=99", count2, prev2);
                end
            end
            prev2 = count2;
        end
        total++;
        if (count2 !== 8'h00 || wrap2 !== 1'b1) begin
            bad++;
            $display("FAIL wrap_100: count=%h wrap=%b required count=00 wrap=1", count2, wrap2);
        end
        @(posedge clk); #1;
        total++;
        if (wrap2 !== 1'b0 || count2 !== 8'h00) begin
            bad++;
            $display("FAIL wrap_after: count=%h wrap=%b required count=00 wrap=0", count2, wrap2);
        end
        total++;
        if (wraps != 1) begin
            bad++;
            $display("FAIL wrap_pulses: pulses=%0d required 1", wraps);
        end
        total++;
        if (an2 !== 2'b10 && an2 !== 2'b01) begin
            bad++;
            $display("FAIL an2_select: an=%b required one low bit", an2);
        end
        en2 = 1'b0;
    endtask

    task automatic test_en_clr();
        int n;
        clear_count();
        count_to(5);
        repeat (20) step();
        total++;
        if (count_bcd !== 16'h0005) begin
            bad++;
            $display("FAIL en_hold: count_bcd=%h required 0005", count_bcd);
        end
        en = 1'b1;
        n = 0;
        while (m_pre != TD - 1 && n < 10) begin
            step();
            n++;
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        en = 1'b0;
        total++;
        if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL clr_tick: count_bcd=%h wrap=%b required 0000 wrap=0", count_bcd, wrap);
        end
        step();
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [8];
        logic [3:0] exp_dg [8];
        logic [3:0] prev_an;
        logic       found;
        exp_an = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};
        exp_dg = '{4'h5, 4'h5, 4'h0, 4'h0, 4'h3, 4'h3, 4'h0, 4'h0};
        clear_count();
        blank_lz = 1'b0;
        count_to(305);
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            prev_an = an;
            step();
            if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL scan_sync: an=%b required a 0111 -> 1110 transition", an);
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            total++;
            if (an !== exp_an[i] || digit !== exp_dg[i]) begin
                bad++;
                $display("FAIL scan_seq[%0d]: an=%b digit=%h required an=%b digit=%h",
                         i, an, digit, exp_an[i], exp_dg[i]);
            end
        end
    endtask

    task automatic collect(input logic [15:0] exp, input string name);
        logic [15:0] shown;
        shown = '0;
        step();
        step();
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            case (an)
                4'b1110: shown[3:0]   = digit;
                4'b1101: shown[7:4]   = digit;
                4'b1011: shown[11:8]  = digit;
                4'b0111: shown[15:12] = digit;
                default: begin
                    bad++;
                    $display("FAIL %s_select: an=%b required exactly one low bit", name, an);
                end
            endcase
        end
        total++;
        if (shown !== exp) begin
            bad++;
            $display("FAIL %s: digits(3..0)=%h required %h", name, shown, exp);
        end
    endtask

    task automatic test_blanking();
        clear_count();
        count_to(7);
        blank_lz = 1'b1;
        collect(16'hFFF7, "blank_7");
        blank_lz = 1'b0;
        collect(16'h0007, "noblank_7");
        clear_count();
        blank_lz = 1'b1;
        collect(16'hFFF0, "blank_0");
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; blank_lz = 1'b0;
        rst2_n = 1'b0; en2 = 1'b0; clr2 = 1'b0; blank2 = 1'b0;
        test_reset();
        test_count_carry();
        test_wrap();
        test_en_clr();
        test_scan();
        test_blanking();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
